// File: rtl/guard_recovery_ctrl_pkg.sv
// Shared definitions for the guard recovery controller.
//   guard_state_e   : recovery sequencer states
//   hold_cnt_width(): counter width needed to count RstHoldCycles-1 down to 0
package guard_recovery_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISOLATE    = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_SLV_RESET  = 3'd3,
    ST_WAIT_CLEAR = 3'd4
  } guard_state_e;

  localparam int unsigned CauseWidth = 2;

  // The hold counter is loaded with hold_cycles-1, so it needs clog2(hold_cycles)
  // bits; keep at least one bit so hold_cycles of 1 or 2 still elaborates.
  function automatic int hold_cnt_width(input int hold_cycles);
    if (hold_cycles <= 2) begin
      return 1;
    end
    return $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/guard_down_counter.sv
// Loadable down-counter with zero flag, used for both drain budget and
// slave-reset hold timing.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (counter -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one (no wrap below zero)
//   zero_o     : counter currently equals zero
module guard_down_counter #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/guard_recovery_ctrl.sv
// Recovery sequencer for a guarded slave: on a write/read guard reset request
// it isolates the slave, drains outstanding transactions (bounded by a
// budget), holds the slave in reset, then waits for a software acknowledge
// before clearing the guards.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | normal operation, watching for guard reset requests
// ST_ISOLATE    | one cycle: block new AW/AR, load drain budget
// ST_DRAIN      | wait for outstanding count to reach zero or budget expiry
// ST_SLV_RESET  | slave reset held for RstHoldCycles cycles
// ST_WAIT_CLEAR | wait for software acknowledge, then pulse guard_clear_o
//
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   wr/rd_reset_req_i      : level reset requests from the guards
//   wr/rd_outst_i          : outstanding transaction counts
//   drain_budget_i         : max drain cycles
//   reset_clear_i          : software acknowledge pulse
//   isolate_o, irq_o       : high in every non-idle state
//   slv_reset_o            : reset to the guarded slave
//   guard_clear_o          : one-cycle guard clear pulse
//   cause_o                : latched {rd,wr} cause
//   drain_timeout_o        : drain ended by budget expiry
//   evt_cnt_o              : saturating count of recoveries started
module guard_recovery_ctrl
  import guard_recovery_ctrl_pkg::*;
#(
  parameter int OutstWidth    = 6,
  parameter int DrainCntWidth = 8,
  parameter int RstHoldCycles = 16,
  parameter int EvtCntWidth   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_reset_req_i,
  input  logic                     rd_reset_req_i,
  input  logic [OutstWidth-1:0]    wr_outst_i,
  input  logic [OutstWidth-1:0]    rd_outst_i,
  input  logic [DrainCntWidth-1:0] drain_budget_i,
  input  logic                     reset_clear_i,
  output logic                     isolate_o,
  output logic                     slv_reset_o,
  output logic                     guard_clear_o,
  output logic                     irq_o,
  output logic [CauseWidth-1:0]    cause_o,
  output logic                     drain_timeout_o,
  output logic [EvtCntWidth-1:0]   evt_cnt_o
);

  localparam int HoldW = hold_cnt_width(RstHoldCycles);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(RstHoldCycles - 1);

  guard_state_e state_q, state_d;

  logic                  any_req;
  logic [CauseWidth-1:0] req_vec;
  logic                  outst_zero;
  logic                  drain_load, drain_dec, drain_zero;
  logic                  hold_load, hold_dec, hold_zero;
  logic                  start_rec;
  logic                  set_timeout;
  logic                  clear_pulse;

  assign req_vec    = {rd_reset_req_i, wr_reset_req_i};
  assign any_req    = |req_vec;
  assign outst_zero = (wr_outst_i == '0) && (rd_outst_i == '0);

  guard_down_counter #(.Width(DrainCntWidth)) u_drain_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (drain_load),
    .load_val_i (drain_budget_i),
    .dec_i      (drain_dec),
    .zero_o     (drain_zero)
  );

  // Loaded with RstHoldCycles-1 on the DRAIN exit so that SLV_RESET, which
  // leaves when the counter reads zero, lasts exactly RstHoldCycles cycles.
  guard_down_counter #(.Width(HoldW)) u_hold_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (hold_load),
    .load_val_i (HoldLoad),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_load  = 1'b0;
    drain_dec   = 1'b0;
    hold_load   = 1'b0;
    hold_dec    = 1'b0;
    start_rec   = 1'b0;
    set_timeout = 1'b0;
    clear_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_ISOLATE;
          start_rec = 1'b1;
        end
      end
      ST_ISOLATE: begin
        drain_load = 1'b1;
        state_d    = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outst_zero) begin
          state_d   = ST_SLV_RESET;
          hold_load = 1'b1;
        end else if (drain_zero) begin
          state_d     = ST_SLV_RESET;
          hold_load   = 1'b1;
          set_timeout = 1'b1;
        end else begin
          drain_dec = 1'b1;
        end
      end
      ST_SLV_RESET: begin
        if (hold_zero) begin
          state_d = ST_WAIT_CLEAR;
        end else begin
          hold_dec = 1'b1;
        end
      end
      ST_WAIT_CLEAR: begin
        if (reset_clear_i) begin
          state_d     = ST_IDLE;
          clear_pulse = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cause/timeout persist through IDLE until the next recovery starts; late
  // requests during a running recovery only widen the cause.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_o         <= '0;
      drain_timeout_o <= 1'b0;
      evt_cnt_o       <= '0;
    end else if (start_rec) begin
      cause_o         <= req_vec;
      drain_timeout_o <= 1'b0;
      if (evt_cnt_o != '1) begin
        evt_cnt_o <= evt_cnt_o + 1'b1;
      end
    end else begin
      if (state_q != ST_IDLE) begin
        cause_o <= cause_o | req_vec;
      end
      if (set_timeout) begin
        drain_timeout_o <= 1'b1;
      end
    end
  end

  assign isolate_o     = (state_q != ST_IDLE);
  assign irq_o         = (state_q != ST_IDLE);
  assign slv_reset_o   = (state_q == ST_SLV_RESET);
  assign guard_clear_o = clear_pulse;

endmodule

// File: tb/tb_guard_recovery_ctrl.sv
module tb_guard_recovery_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_reset_req_i, rd_reset_req_i;
  logic [5:0] wr_outst_i, rd_outst_i;
  logic [7:0] drain_budget_i;
  logic       reset_clear_i;
  logic       isolate_o, slv_reset_o, guard_clear_o, irq_o;
  logic [1:0] cause_o;
  logic       drain_timeout_o;
  logic [7:0] evt_cnt_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] cause;
    logic       tmo;
    int         pre;   // ISOLATE + DRAIN cycles
    int         hold;  // slv_reset_o high cycles
    logic [7:0] evt;
  } exp_t;

  exp_t sb[$];

  guard_recovery_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .wr_reset_req_i  (wr_reset_req_i),
    .rd_reset_req_i  (rd_reset_req_i),
    .wr_outst_i      (wr_outst_i),
    .rd_outst_i      (rd_outst_i),
    .drain_budget_i  (drain_budget_i),
    .reset_clear_i   (reset_clear_i),
    .isolate_o       (isolate_o),
    .slv_reset_o     (slv_reset_o),
    .guard_clear_o   (guard_clear_o),
    .irq_o           (irq_o),
    .cause_o         (cause_o),
    .drain_timeout_o (drain_timeout_o),
    .evt_cnt_o       (evt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Monitor: measures each recovery and compares it against the scoreboard
  // on the first WAIT_CLEAR cycle.
  int   mon_pre  = 0;
  int   mon_hold = 0;
  logic mon_prev = 1'b0;
  exp_t e;

  always @(negedge clk_i) begin
    if (rst_i || !isolate_o) begin
      mon_pre  = 0;
      mon_hold = 0;
      mon_prev = 1'b0;
    end else begin
      if (slv_reset_o) begin
        mon_hold++;
      end else if (mon_prev) begin
        chk("sb_level", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("mon_cause", cause_o, e.cause);
          chk("mon_tmo", drain_timeout_o, e.tmo);
          chk("mon_pre", mon_pre, e.pre);
          chk("mon_hold", mon_hold, e.hold);
          chk("mon_evt", evt_cnt_o, e.evt);
        end
      end else if (mon_hold == 0) begin
        mon_pre++;
      end
      mon_prev = slv_reset_o;
    end
  end

  task automatic push(input logic [1:0] c, input logic t, input int p, input int h, input int ev);
    exp_t x;
    x.cause = c; x.tmo = t; x.pre = p; x.hold = h; x.evt = ev[7:0];
    sb.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_slv(input logic lvl);
    int n;
    n = 0;
    while (slv_reset_o !== lvl && n < 400) begin
      cyc(1);
      n++;
    end
    chk("wait_slv", slv_reset_o, lvl);
  endtask

  task automatic clear_pulse();
    reset_clear_i = 1'b1;
    @(negedge clk_i);
    chk("gclr_hi", guard_clear_o, 1);
    @(posedge clk_i);
    #1;
    reset_clear_i = 1'b0;
    chk("gclr_idle", isolate_o, 0);
    chk("gclr_lo", guard_clear_o, 0);
  endtask

  task automatic recover(input logic w, input logic r);
    wr_reset_req_i = w;
    rd_reset_req_i = r;
    cyc(1);
    wr_reset_req_i = 1'b0;
    rd_reset_req_i = 1'b0;
    wait_slv(1);
    wait_slv(0);
    clear_pulse();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_iso"}, isolate_o, 0);
    chk({tag, "_slv"}, slv_reset_o, 0);
    chk({tag, "_gclr"}, guard_clear_o, 0);
    chk({tag, "_irq"}, irq_o, 0);
    chk({tag, "_cause"}, cause_o, 0);
    chk({tag, "_tmo"}, drain_timeout_o, 0);
    chk({tag, "_evt"}, evt_cnt_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    wr_reset_req_i = 1'b0;
    rd_reset_req_i = 1'b0;
    wr_outst_i = '0;
    rd_outst_i = '0;
    drain_budget_i = '0;
    reset_clear_i = 1'b0;
    cyc(2);
    chk_all_zero("rst");
    rst_i = 1'b0;
    cyc(1);

    // write request, nothing outstanding
    drain_budget_i = 8'd10;
    push(2'b01, 1'b0, 2, 16, 1);
    wr_reset_req_i = 1'b1;
    cyc(1);
    wr_reset_req_i = 1'b0;
    chk("s1_iso", isolate_o, 1);
    chk("s1_evt", evt_cnt_o, 1);
    wait_slv(1);
    wait_slv(0);
    chk("s1_irq_wc", irq_o, 1);
    clear_pulse();
    chk("s1_cause_hold", cause_o, 2'b01);
    chk("s1_irq_idle", irq_o, 0);

    // read request, 3 outstanding cleared after 5 drain-side cycles
    rd_outst_i = 6'd3;
    drain_budget_i = 8'd20;
    push(2'b10, 1'b0, 6, 16, 2);
    rd_reset_req_i = 1'b1;
    cyc(1);
    rd_reset_req_i = 1'b0;
    cyc(5);
    rd_outst_i = '0;
    wait_slv(1);
    wait_slv(0);
    clear_pulse();

    // budget 4 with write outstanding held -> 5 drain cycles, timeout
    wr_outst_i = 6'd2;
    drain_budget_i = 8'd4;
    push(2'b01, 1'b1, 6, 16, 3);
    recover(1'b1, 1'b0);
    chk("s3_tmo_hold", drain_timeout_o, 1);

    // budget 0 with outstanding -> one drain cycle, timeout
    wr_outst_i = 6'd1;
    drain_budget_i = 8'd0;
    push(2'b01, 1'b1, 2, 16, 4);
    recover(1'b1, 1'b0);
    wr_outst_i = '0;

    // fresh reset, simultaneous requests, early acknowledge ignored
    rst_i = 1'b1;
    cyc(1);
    rst_i = 1'b0;
    push(2'b11, 1'b0, 2, 16, 1);
    wr_reset_req_i = 1'b1;
    rd_reset_req_i = 1'b1;
    cyc(1);
    wr_reset_req_i = 1'b0;
    rd_reset_req_i = 1'b0;
    wait_slv(1);
    reset_clear_i = 1'b1;
    @(negedge clk_i);
    chk("s4_ignored", guard_clear_o, 0);
    @(posedge clk_i);
    #1;
    reset_clear_i = 1'b0;
    wait_slv(0);
    chk("s4_wc_iso", isolate_o, 1);
    clear_pulse();
    chk("s4_cause", cause_o, 2'b11);
    chk("s4_evt", evt_cnt_o, 1);

    // read request arriving mid-recovery widens cause, no new event
    push(2'b11, 1'b0, 2, 16, 2);
    wr_reset_req_i = 1'b1;
    cyc(1);
    wr_reset_req_i = 1'b0;
    wait_slv(1);
    rd_reset_req_i = 1'b1;
    cyc(1);
    rd_reset_req_i = 1'b0;
    wait_slv(0);
    clear_pulse();
    chk("s5_evt", evt_cnt_o, 2);

    // request held through the acknowledge restarts a recovery
    push(2'b01, 1'b0, 2, 16, 3);
    push(2'b01, 1'b0, 2, 16, 4);
    wr_reset_req_i = 1'b1;
    wait_slv(1);
    wait_slv(0);
    clear_pulse();
    cyc(1);
    wr_reset_req_i = 1'b0;
    chk("s6_restart", isolate_o, 1);
    wait_slv(1);
    wait_slv(0);
    clear_pulse();
    chk("s6_evt", evt_cnt_o, 4);

    // reset in the middle of SLV_RESET
    wr_reset_req_i = 1'b1;
    cyc(1);
    wr_reset_req_i = 1'b0;
    wait_slv(1);
    cyc(3);
    rst_i = 1'b1;
    cyc(1);
    chk_all_zero("midrst");
    rst_i = 1'b0;
    cyc(1);

    // saturation of the event counter
    drain_budget_i = 8'd0;
    for (int i = 0; i < 256; i++) begin
      push(2'b01, 1'b0, 2, 16, (i >= 255) ? 255 : i + 1);
      recover(1'b1, 1'b0);
    end
    chk("evt_sat", evt_cnt_o, 255);

    cyc(2);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guard_recovery_ctrl.md
GUARD_RECOVERY_CTRL -- requirements
Module: guard_recovery_ctrl

Interface
REQ-001 SHALL have parameter OutstWidth, default 6, width of each outstanding-transaction count input.
REQ-002 SHALL have parameter DrainCntWidth, default 8, width of the drain budget and drain counter.
REQ-003 SHALL have parameter RstHoldCycles, default 16, number of cycles slv_reset_o is held (>=1).
REQ-004 SHALL have parameter EvtCntWidth, default 8, width of the recovery event counter.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port wr_reset_req_i  input  1  level reset request from the write guard.
REQ-008 SHALL have port rd_reset_req_i  input  1  level reset request from the read guard.
REQ-009 SHALL have port wr_outst_i  input  OutstWidth  outstanding write transactions tracked by the write guard.
REQ-010 SHALL have port rd_outst_i  input  OutstWidth  outstanding read transactions tracked by the read guard.
REQ-011 SHALL have port drain_budget_i  input  DrainCntWidth  max drain cycles (register field).
REQ-012 SHALL have port reset_clear_i  input  1  software acknowledge (register field, single-cycle pulse).
REQ-013 SHALL have port isolate_o  output  1  blocks new AW/AR acceptance towards the slave.
REQ-014 SHALL have port slv_reset_o  output  1  reset to the guarded slave.
REQ-015 SHALL have port guard_clear_o  output  1  one-cycle pulse clearing both guards' reset state.
REQ-016 SHALL have port irq_o  output  1  level interrupt.
REQ-017 SHALL have port cause_o  output  2  latched cause {rd,wr}.
REQ-018 SHALL have port drain_timeout_o  output  1  drain ended by budget expiry.
REQ-019 SHALL have port evt_cnt_o  output  EvtCntWidth  number of recoveries started, saturating.

Function
REQ-020 SHALL implement FSM states IDLE, ISOLATE, DRAIN, SLV_RESET, WAIT_CLEAR.
REQ-021 IDLE: wr_reset_req_i|rd_reset_req_i -> ISOLATE next cycle; cause_o <= {rd,wr} requests; drain_timeout_o <= 0; evt_cnt_o += 1 (saturate at all-ones).
REQ-022 Simultaneous wr/rd requests SHALL start one recovery with cause_o=2'b11.
REQ-023 Requests asserted in any non-IDLE state SHALL be OR-accumulated into cause_o and SHALL NOT restart the sequence or increment evt_cnt_o.
REQ-024 ISOLATE: isolate_o=1, irq_o=1; lasts exactly one cycle, loads drain counter with drain_budget_i, -> DRAIN.
REQ-025 DRAIN: if wr_outst_i==0 and rd_outst_i==0 -> SLV_RESET; else if counter==0 -> SLV_RESET with drain_timeout_o <= 1; else counter decrements by 1.
REQ-026 drain_budget_i==0 with nonzero outstanding SHALL exit DRAIN after its first cycle with drain_timeout_o=1.
REQ-027 SLV_RESET: slv_reset_o=1 for exactly RstHoldCycles consecutive cycles, then -> WAIT_CLEAR.
REQ-028 WAIT_CLEAR: slv_reset_o=0; reset_clear_i -> IDLE with guard_clear_o=1 for that single transition cycle.
REQ-029 reset_clear_i in states other than WAIT_CLEAR SHALL be ignored (not stored).
REQ-030 isolate_o and irq_o SHALL be 1 in every state except IDLE; both 0 in IDLE.
REQ-031 A request still asserted in the IDLE cycle after guard_clear_o SHALL start a new recovery.
REQ-032 cause_o and drain_timeout_o SHALL hold their values through IDLE until the next recovery starts.

Reset
REQ-033 rst_i SHALL force IDLE, counters to 0, cause_o=0, drain_timeout_o=0, evt_cnt_o=0, all other outputs 0, on the next rising edge, from any state including mid-DRAIN/SLV_RESET.

Structure
REQ-034 State enum and RstHoldCycles-derived hold-counter width SHALL live in the shared guard package.
REQ-035 Drain and hold counting SHALL use one sub-module, guard_down_counter (load, decrement-enable, zero flag).

Verification
REQ-036 wr_reset_req_i pulse, outst 0/0 -> ISOLATE 1 cycle, DRAIN 1 cycle, slv_reset_o high 16 cycles, cause_o=01, drain_timeout_o=0.
REQ-037 rd_reset_req_i, rd_outst_i=3 cleared after 5 cycles, budget 20 -> SLV_RESET entered, drain_timeout_o=0, cause_o=10.
REQ-038 wr request, wr_outst_i=2 held, budget 4 -> DRAIN lasts 5 cycles, drain_timeout_o=1.
REQ-039 Simultaneous wr/rd, then reset_clear_i during SLV_RESET and again in WAIT_CLEAR -> first ignored, second yields one guard_clear_o pulse, cause_o=11, evt_cnt_o=1.
REQ-040 rst_i asserted mid-SLV_RESET -> next cycle all outputs 0, evt_cnt_o=0; 256 recoveries with EvtCntWidth=8 -> evt_cnt_o stays 255.
